// File: rtl/adam_mem_banked_pkg.sv
// Shared types and elaboration helpers for the word-interleaved banked memory.
package adam_mem_banked_pkg;

   localparam int unsigned MaxBankBits = 4;

   // One in-flight response slot; bank selects which bank output carries the read data.
   typedef struct packed {
      logic                   valid;
      logic                   is_write;
      logic [MaxBankBits-1:0] bank;
   } rsp_entry_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit banks_legal(input int unsigned n);
      return (n >= 1) && (n <= 16) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit latency_legal(input int unsigned n);
      return (n >= 1) && (n <= 4);
   endfunction

endpackage

// File: rtl/adam_mem_bank.sv
// Single-port byte-enable SRAM bank with a RD_LATENCY-deep read data pipeline.
module adam_mem_bank
   import adam_mem_banked_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROWS       = 1024,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned NO_BANKS   = 1,
   parameter int unsigned BANK       = 0,
   parameter string       INIT_FILE  = ""
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          we,
   input  logic [idx_width(ROWS)-1:0]    row,
   input  logic [DATA_WIDTH/8-1:0]       be,
   input  logic [DATA_WIDTH-1:0]         wdata,
   output logic [DATA_WIDTH-1:0]         rdata
);

   logic [DATA_WIDTH-1:0] mem    [ROWS];
   logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY];

   if (BANK >= NO_BANKS) begin : g_bad_bank
      $error("adam_mem_bank: BANK index out of range");
   end

   // Memory has no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (be[i]) mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         if (en && !we) pipe_q[0] <= mem[row];
         for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign rdata = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/adam_mem_banked.sv
// Multi-port word-interleaved memory: address decode, per-bank round-robin arbitration
// and per-port response steering.
module adam_mem_banked
   import adam_mem_banked_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SIZE       = 524288,
   parameter int unsigned NO_PORTS   = 2,
   parameter int unsigned NO_BANKS   = 4,
   parameter int unsigned RD_LATENCY = 1,
   parameter string       INIT_FILE  = ""
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NO_PORTS-1:0]                     req,
   output logic [NO_PORTS-1:0]                     gnt,
   input  logic [NO_PORTS-1:0][ADDR_WIDTH-1:0]     addr,
   input  logic [NO_PORTS-1:0]                     we,
   input  logic [NO_PORTS-1:0][DATA_WIDTH/8-1:0]   be,
   input  logic [NO_PORTS-1:0][DATA_WIDTH-1:0]     wdata,
   output logic [NO_PORTS-1:0]                     rvalid,
   output logic [NO_PORTS-1:0][DATA_WIDTH-1:0]     rdata
);

   localparam int unsigned Bytes    = DATA_WIDTH / 8;
   localparam int unsigned OffBits  = $clog2(Bytes);
   localparam int unsigned BankBits = idx_width(NO_BANKS);
   localparam int unsigned PortBits = idx_width(NO_PORTS);
   localparam int unsigned Rows     = SIZE / (NO_BANKS * Bytes);
   localparam int unsigned RowBits  = idx_width(Rows);

   if (!banks_legal(NO_BANKS)) begin : g_bad_banks
      $error("adam_mem_banked: NO_BANKS must be a power of two in 1..16");
   end
   if (!latency_legal(RD_LATENCY)) begin : g_bad_latency
      $error("adam_mem_banked: RD_LATENCY must be in 1..4");
   end

   logic [NO_PORTS-1:0][BankBits-1:0]   bank_idx;
   logic [NO_PORTS-1:0][RowBits-1:0]    row_idx;
   logic [NO_BANKS-1:0][PortBits-1:0]   ptr_q, ptr_d;
   logic [NO_BANKS-1:0][PortBits-1:0]   bank_win;
   logic [NO_BANKS-1:0]                 bank_en;
   logic [NO_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
   rsp_entry_t                          rsp_q [NO_PORTS][RD_LATENCY];

   // Out-of-range addresses wrap through the row modulo.
   always_comb begin
      logic [ADDR_WIDTH-1:0] word;
      word     = '0;
      bank_idx = '0;
      row_idx  = '0;
      for (int p = 0; p < NO_PORTS; p++) begin
         word        = addr[p] >> OffBits;
         bank_idx[p] = BankBits'(word % ADDR_WIDTH'(NO_BANKS));
         row_idx[p]  = RowBits'((word / ADDR_WIDTH'(NO_BANKS)) % ADDR_WIDTH'(Rows));
      end
   end

   // Winner is the first requester at or after ptr, scanning in wrap order.
   always_comb begin
      logic [PortBits:0]   cand;
      logic [PortBits-1:0] idx;
      cand     = '0;
      idx      = '0;
      ptr_d    = ptr_q;
      bank_win = '0;
      bank_en  = '0;
      gnt      = '0;
      if (rst_n) begin
         for (int b = 0; b < NO_BANKS; b++) begin
            for (int k = 0; k < NO_PORTS; k++) begin
               cand = {1'b0, ptr_q[b]} + (PortBits+1)'(k);
               if (cand >= (PortBits+1)'(NO_PORTS)) cand = cand - (PortBits+1)'(NO_PORTS);
               idx = cand[PortBits-1:0];
               if (!bank_en[b] && req[idx] && (bank_idx[idx] == BankBits'(b))) begin
                  bank_en[b]  = 1'b1;
                  bank_win[b] = idx;
                  gnt[idx]    = 1'b1;
                  ptr_d[b]    = (idx == PortBits'(NO_PORTS - 1)) ? '0 : idx + PortBits'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   for (genvar b = 0; b < NO_BANKS; b++) begin : g_bank
      adam_mem_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ROWS       (Rows),
         .RD_LATENCY (RD_LATENCY),
         .NO_BANKS   (NO_BANKS),
         .BANK       (b),
         .INIT_FILE  (INIT_FILE)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (bank_en[b]),
         .we    (we[bank_win[b]]),
         .row   (row_idx[bank_win[b]]),
         .be    (be[bank_win[b]]),
         .wdata (wdata[bank_win[b]]),
         .rdata (bank_rdata[b])
      );
   end

   // Per-port tags run in lockstep with the bank data pipelines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NO_PORTS; p++) begin
            for (int s = 0; s < RD_LATENCY; s++) rsp_q[p][s] <= '0;
         end
      end else begin
         for (int p = 0; p < NO_PORTS; p++) begin
            rsp_q[p][0] <= '{valid: gnt[p], is_write: we[p],
                             bank: MaxBankBits'(bank_idx[p])};
            for (int s = 1; s < RD_LATENCY; s++) rsp_q[p][s] <= rsp_q[p][s-1];
         end
      end
   end

   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int p = 0; p < NO_PORTS; p++) begin
         rvalid[p] = rsp_q[p][RD_LATENCY-1].valid;
         for (int b = 0; b < NO_BANKS; b++) begin
            if (rsp_q[p][RD_LATENCY-1].valid && !rsp_q[p][RD_LATENCY-1].is_write &&
                (rsp_q[p][RD_LATENCY-1].bank == MaxBankBits'(b))) begin
               rdata[p] = bank_rdata[b];
            end
         end
      end
   end

endmodule

// File: tb/tb_adam_mem_banked.sv
// Directed bench for adam_mem_banked: 2 ports, 4 banks, RD_LATENCY=3, SIZE=1024.
module tb_adam_mem_banked;

   localparam int unsigned NP = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NP-1:0]              req, gnt, we, rvalid;
   logic [NP-1:0][AW-1:0]      addr;
   logic [NP-1:0][DW/8-1:0]    be;
   logic [NP-1:0][DW-1:0]      wdata, rdata;
   int                         checks   = 0;
   int                         failures = 0;

   always #5 clk = ~clk;

   adam_mem_banked #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .SIZE       (1024),
      .NO_PORTS   (NP),
      .NO_BANKS   (4),
      .RD_LATENCY (3),
      .INIT_FILE  ("")
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .gnt    (gnt),
      .addr   (addr),
      .we     (we),
      .be     (be),
      .wdata  (wdata),
      .rvalid (rvalid),
      .rdata  (rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
      req[p] = 1'b1; we[p] = 1'b1; addr[p] = a; wdata[p] = d; be[p] = b;
   endtask

   task automatic rd(input int p, input logic [31:0] a);
      req[p] = 1'b1; we[p] = 1'b0; addr[p] = a; be[p] = 4'h0; wdata[p] = '0;
   endtask

   task automatic idle(input int p);
      req[p] = 1'b0; we[p] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      rd(0, 32'h10);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata0", rdata[0], 0);
      chk("rst_rdata1", rdata[1], 0);
      @(negedge clk); rst_n = 1'b1; idle(0);

      // Single write then read, latency 3
      @(negedge clk); wr(0, 32'h10, 32'hDEADBEEF, 4'hF); #1;
      chk("wr_gnt", gnt, 2'b01);
      @(negedge clk); rd(0, 32'h10); #1;
      chk("rd_gnt", gnt, 2'b01);
      chk("lat_early1", rvalid, 0);
      @(negedge clk); idle(0); #1;
      chk("lat_early2", rvalid, 0);
      @(negedge clk); #1;
      chk("wr_rvalid", rvalid, 2'b01);
      chk("wr_rdata", rdata[0], 0);
      @(negedge clk); #1;
      chk("rd_rvalid", rvalid, 2'b01);
      chk("rd_rdata", rdata[0], 32'hDEADBEEF);
      @(negedge clk); #1;
      chk("rvalid_drop", rvalid, 0);

      // Byte enables
      @(negedge clk); wr(0, 32'h20, 32'h11223344, 4'hF);
      @(negedge clk); wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
      @(negedge clk); rd(0, 32'h20);
      @(negedge clk); idle(0);
      repeat (2) @(negedge clk);
      #1;
      chk("be_rvalid", rvalid, 2'b01);
      chk("be_rdata", rdata[0], 32'h11BB33DD);

      // Bank 1 conflict, preloaded through port 1
      @(negedge clk); wr(1, 32'h04, 32'h04040404, 4'hF); #1;
      chk("pre_gnt", gnt, 2'b10);
      @(negedge clk); wr(1, 32'h14, 32'h14141414, 4'hF);
      @(negedge clk); idle(1);
      @(negedge clk); rd(0, 32'h04); rd(1, 32'h14); #1;
      chk("cf_gnt0", gnt, 2'b01);
      @(negedge clk); #1;
      chk("cf_gnt1", gnt, 2'b10);
      @(negedge clk); #1;
      chk("cf_gnt2", gnt, 2'b01);
      @(negedge clk); #1;
      chk("cf_gnt3", gnt, 2'b10);
      chk("cf_rv0", rvalid, 2'b01);
      chk("cf_rd0", rdata[0], 32'h04040404);
      @(negedge clk); idle(0); idle(1); #1;
      chk("cf_rv1", rvalid, 2'b10);
      chk("cf_rd1", rdata[1], 32'h14141414);

      // Address wrap: 0x400 aliases 0x000 with 1 KiB
      @(negedge clk); wr(0, 32'h400, 32'h5A5A5A5A, 4'hF); #1;
      chk("wrap_wgnt", gnt, 2'b01);
      @(negedge clk); rd(0, 32'h000);
      @(negedge clk); idle(0);
      repeat (2) @(negedge clk);
      #1;
      chk("wrap_rvalid", rvalid, 2'b01);
      chk("wrap_rdata", rdata[0], 32'h5A5A5A5A);

      // Parallel banks
      @(negedge clk); rd(0, 32'h00); rd(1, 32'h04); #1;
      chk("par_gnt", gnt, 2'b11);
      @(negedge clk); idle(0); idle(1);
      @(negedge clk); #1;
      chk("par_early", rvalid, 0);
      @(negedge clk); #1;
      chk("par_rvalid", rvalid, 2'b11);
      chk("par_rdata0", rdata[0], 32'h5A5A5A5A);
      chk("par_rdata1", rdata[1], 32'h04040404);

      // Reset with reads in flight; bank 1 pointer left at port 1 beforehand
      @(negedge clk); rd(0, 32'h04); #1;
      chk("mf_gnt0", gnt, 2'b01);
      @(negedge clk); rd(0, 32'h10);
      @(negedge clk); rd(0, 32'h20); rst_n = 1'b0; #1;
      chk("mf_gnt_rst", gnt, 0);
      chk("mf_rv_rst", rvalid, 0);
      @(negedge clk); #1;
      chk("mf_rv_rst2", rvalid, 0);
      rst_n = 1'b1; idle(0);
      @(negedge clk); #1;
      chk("mf_rv_post1", rvalid, 0);
      @(negedge clk); #1;
      chk("mf_rv_post2", rvalid, 0);
      @(negedge clk); rd(0, 32'h04); rd(1, 32'h14); #1;
      chk("mf_ptr", gnt, 2'b01);
      @(negedge clk); idle(0); #1;
      chk("mf_gnt_p1", gnt, 2'b10);
      @(negedge clk); idle(1); rd(0, 32'h10); #1;
      chk("mf_gnt_b0", gnt, 2'b01);
      @(negedge clk); idle(0); #1;
      chk("mf_rv0", rvalid, 2'b01);
      chk("mf_mem0", rdata[0], 32'h04040404);
      @(negedge clk); #1;
      chk("mf_rv1", rvalid, 2'b10);
      chk("mf_mem1", rdata[1], 32'h14141414);
      @(negedge clk); #1;
      chk("mf_rv2", rvalid, 2'b01);
      chk("mf_mem2", rdata[0], 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
